// File: rtl/dmem_responder.sv
// MEM-stage data memory: word array with WAIT_STATES stall cycles per access and misalignment flagging.
// Define DMEM_SUBWORD_EN for byte/halfword loads and stores decoded from i_funct3.
module dmem_responder #(
   parameter int OPERAND_WIDTH = 32,
   parameter int DEPTH         = 1024,
   parameter int WAIT_STATES   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_ctrl_mem_read,
   input  logic                     i_ctrl_mem_write,
   input  logic [OPERAND_WIDTH-1:0] i_addr,
   input  logic [OPERAND_WIDTH-1:0] i_wdata,
   input  logic [2:0]               i_funct3,
   output logic [OPERAND_WIDTH-1:0] o_rdata,
   output logic                     o_stall,
   output logic                     o_misaligned
);
   // state | meaning
   // IDLE  | no access in flight; requests are accepted and alignment is checked here
   // WAIT  | counting wait states; cnt_q == 0 is the completion cycle
   localparam int         ADDR_W   = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);
   localparam bit         HAS_WAIT = (WAIT_STATES != 0);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [OPERAND_WIDTH-1:0] mem_q [DEPTH];

   logic                     req, is_load, bad_align, complete, stall, mem_we;
   logic [ADDR_W-1:0]        idx;
   logic [OPERAND_WIDTH-1:0] word_rd, load_data, mem_d;
   logic                     unused_in;

   assign req     = i_ctrl_mem_read | i_ctrl_mem_write;
   assign is_load = i_ctrl_mem_read & ~i_ctrl_mem_write;
   assign idx     = i_addr[ADDR_W+1:2];
   assign word_rd = mem_q[idx];

`ifdef DMEM_SUBWORD_EN
   logic [3:0]  lane_en;
   logic [31:0] lane_data, rd_shift;

   // Stores merge the selected lanes into the current word; loads shift the lane down, then extend.
   always_comb begin
      bad_align = 1'b0;
      lane_en   = 4'b0000;
      lane_data = i_wdata;
      load_data = word_rd;
      mem_d     = word_rd;
      rd_shift  = word_rd >> {i_addr[1:0], 3'b000};
      case (i_funct3)
         3'b000, 3'b100: begin
            lane_en   = 4'b0001 << i_addr[1:0];
            lane_data = {4{i_wdata[7:0]}};
            load_data = {{24{rd_shift[7] & ~i_funct3[2]}}, rd_shift[7:0]};
         end
         3'b001, 3'b101: begin
            bad_align = i_addr[0];
            lane_en   = i_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{i_wdata[15:0]}};
            load_data = {{16{rd_shift[15] & ~i_funct3[2]}}, rd_shift[15:0]};
         end
         3'b010: begin
            bad_align = (i_addr[1:0] != 2'b00);
            lane_en   = 4'b1111;
         end
         default: bad_align = 1'b1;
      endcase
      for (int b = 0; b < 4; b++) begin
         mem_d[8*b +: 8] = lane_en[b] ? lane_data[8*b +: 8] : word_rd[8*b +: 8];
      end
   end

   assign unused_in = ^i_addr[OPERAND_WIDTH-1:ADDR_W+2];
`else
   assign bad_align = (i_addr[1:0] != 2'b00);
   assign load_data = word_rd;
   assign mem_d     = i_wdata;
   assign unused_in = ^{i_funct3, i_addr[OPERAND_WIDTH-1:ADDR_W+2]};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && !bad_align) begin
               if (HAS_WAIT) begin
                  stall   = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               stall = 1'b1;
               cnt_d = cnt_q - 4'd1;
            end else begin
               complete = req & ~bad_align;
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   // rst gates every output so nothing leaks through the combinational paths during reset.
   assign mem_we       = complete & i_ctrl_mem_write & ~rst;
   assign o_stall      = stall & ~rst;
   assign o_misaligned = (state_q == ST_IDLE) & req & bad_align & ~rst;
   assign o_rdata      = (complete & is_load & ~rst) ? load_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array is not reset; an access aborted by rst never asserts mem_we.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx] <= mem_d;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (0, 2 and 3 wait states) against a memory model.
module tb_dmem_responder;
   localparam int DEPTH = 1024;

   logic        clk;
   logic        rst   [3];
   logic        rd    [3];
   logic        wr    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [2:0]  f3    [3];
   logic [31:0] rdata [3];
   logic        stall [3];
   logic        mis   [3];

   typedef struct {
      int          stalls;
      bit          mis;
      logic [31:0] rdata;
      int          id;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [int];
   int          tests = 0;
   int          fails = 0;
   int          op_id = 0;
   int          cur   = 0;
   int          mon_run = 0;
   exp_t        mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_responder #(.OPERAND_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst[0]), .i_ctrl_mem_read(rd[0]), .i_ctrl_mem_write(wr[0]),
      .i_addr(addr[0]), .i_wdata(wdata[0]), .i_funct3(f3[0]),
      .o_rdata(rdata[0]), .o_stall(stall[0]), .o_misaligned(mis[0]));

   dmem_responder #(.OPERAND_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst(rst[1]), .i_ctrl_mem_read(rd[1]), .i_ctrl_mem_write(wr[1]),
      .i_addr(addr[1]), .i_wdata(wdata[1]), .i_funct3(f3[1]),
      .o_rdata(rdata[1]), .o_stall(stall[1]), .o_misaligned(mis[1]));

   dmem_responder #(.OPERAND_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst[2]), .i_ctrl_mem_read(rd[2]), .i_ctrl_mem_write(wr[2]),
      .i_addr(addr[2]), .i_wdata(wdata[2]), .i_funct3(f3[2]),
      .o_rdata(rdata[2]), .o_stall(stall[2]), .o_misaligned(mis[2]));

   function automatic int ws_of(int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int key_of(int k, logic [31:0] a);
      return k * DEPTH + int'((a / 4) % DEPTH);
   endfunction

   function automatic logic [31:0] mget(int key);
      return mdl.exists(key) ? mdl[key] : 32'd0;
   endfunction

   function automatic bit exp_mis(logic [31:0] a, logic [2:0] f);
`ifdef DMEM_SUBWORD_EN
      case (f)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return (a % 2) != 0;
         3'd2:       return (a % 4) != 0;
         default:    return 1'b1;
      endcase
`else
      return (a % 4) != 0;
`endif
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] w, logic [31:0] a, logic [2:0] f);
      logic [31:0] v;
      v = w;
`ifdef DMEM_SUBWORD_EN
      case (f)
         3'd0: begin v = (w >> (8 * (a % 4))) & 32'hFF;   if (v >= 128)   v = v - 256;   end
         3'd4: begin v = (w >> (8 * (a % 4))) & 32'hFF;   end
         3'd1: begin v = (w >> (8 * (a % 4))) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
         3'd5: begin v = (w >> (8 * (a % 4))) & 32'hFFFF; end
         default: v = w;
      endcase
`endif
      return v;
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] a, logic [31:0] d,
                                               logic [2:0] f);
      logic [31:0] mask;
      int          nbytes;
      nbytes = 4;
`ifdef DMEM_SUBWORD_EN
      if (f == 3'd0 || f == 3'd4) nbytes = 1;
      if (f == 3'd1 || f == 3'd5) nbytes = 2;
`endif
      if (nbytes == 4) return d;
      mask = ((32'd1 << (8 * nbytes)) - 1) << (8 * (a % 4));
      return (old & ~mask) | ((d << (8 * (a % 4))) & mask);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic fail_now(string nm, string detail);
      tests++;
      fails++;
      $display("FAIL %s: %s (t=%0t)", nm, detail, $time);
   endtask

   // Issue one request on instance k; expected response goes to the scoreboard before driving.
   task automatic do_req(int k, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
      exp_t e;
      int   key;
      int   n;
      key      = key_of(k, a);
      e.mis    = exp_mis(a, f);
      e.stalls = e.mis ? 0 : ws_of(k);
      e.rdata  = 32'd0;
      e.id     = op_id++;
      if (!e.mis && r && !w) e.rdata = model_load(mget(key), a, f);
      if (!e.mis && w)       mdl[key] = model_store(mget(key), a, d, f);
      sb.push_back(e);
      rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; f3[k] = f;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!stall[k]) break;
      end
      if (n == 40) fail_now("drv_timeout", $sformatf("op%0d never completed", e.id));
      @(posedge clk);
      #1;
      rd[k] = 1'b0;
      wr[k] = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every cycle with a request and no stall is a response to pop and compare.
   initial begin
      forever begin
         @(negedge clk);
         if (rst[cur]) begin
            chk("reset_outputs", {stall[cur], mis[cur], rdata[cur]}, 64'd0);
            mon_run = 0;
         end else if (!(rd[cur] || wr[cur])) begin
            chk("idle_outputs", {stall[cur], mis[cur], rdata[cur]}, 64'd0);
            mon_run = 0;
         end else if (stall[cur]) begin
            mon_run++;
            chk("stalled_outputs", {mis[cur], rdata[cur]}, 64'd0);
            if (mon_run > 20) begin
               fail_now("stall_bound", $sformatf("stall held %0d cycles", mon_run));
               mon_run = 0;
            end
         end else begin
            if (sb.size() == 0) begin
               fail_now("unexpected_response", "response with empty scoreboard");
            end else begin
               mon_e = sb.pop_front();
               chk($sformatf("op%0d_stall_cycles", mon_e.id), mon_run, mon_e.stalls);
               chk($sformatf("op%0d_misaligned", mon_e.id), mis[cur], mon_e.mis);
               chk($sformatf("op%0d_rdata", mon_e.id), rdata[cur], mon_e.rdata);
            end
            mon_run = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          op;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0;
         addr[k] = 32'd0; wdata[k] = 32'd0; f3[k] = 3'b010;
      end
      #1;
      for (int k = 0; k < 3; k++) chk("reset_state", {stall[k], mis[k], rdata[k]}, 64'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      idle(1);

      // Two wait states: store then load.
      cur = 1;
      do_req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
      do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
      idle(1);

      // Single-cycle memory, back-to-back, then a misaligned load.
      cur = 0;
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h1, 3'b010);
      do_req(0, 1'b0, 1'b1, 32'h4, 32'h2, 3'b010);
      do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
      do_req(0, 1'b1, 1'b0, 32'h6, 32'h0, 3'b010);
      do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);
      idle(1);

      // Three wait states: store aborted by reset in its second stall cycle.
      cur = 2;
      rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h55; f3[2] = 3'b010;
      @(negedge clk);
      chk("abort_first_stall", stall[2], 1'b1);
      @(posedge clk);
      #2;
      rst[2] = 1'b1;
      wr[2]  = 1'b0;
      #1;
      chk("abort_stall_drop", stall[2], 1'b0);
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      idle(1);
      do_req(2, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
      idle(1);

      // Address wrap and read+write collision.
      cur = 1;
      do_req(1, 1'b0, 1'b1, 32'h1000, 32'hA5A5, 3'b010);
      do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
      do_req(1, 1'b1, 1'b1, 32'h40, 32'h77, 3'b010);
      do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
      idle(1);

`ifdef DMEM_SUBWORD_EN
      do_req(1, 1'b0, 1'b1, 32'h8, 32'h80FF7F01, 3'b010);
      do_req(1, 1'b1, 1'b0, 32'h9, 32'h0, 3'b000);
      do_req(1, 1'b1, 1'b0, 32'hB, 32'h0, 3'b000);
      do_req(1, 1'b1, 1'b0, 32'hA, 32'h0, 3'b101);
      do_req(1, 1'b0, 1'b1, 32'h8, 32'h12, 3'b000);
      do_req(1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010);
      idle(1);
`endif

      // Randomized traffic on each instance.
      for (int k = 0; k < 3; k++) begin
         cur = k;
         for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)) * 32'h1000;
            if ($urandom_range(0, 9) == 0) a = a | ($urandom() & 32'hFFFF_F000);
`ifdef DMEM_SUBWORD_EN
            a = a + 32'($urandom_range(0, 3));
`else
            if ($urandom_range(0, 6) == 0) a = a + 32'($urandom_range(1, 3));
`endif
            if (op < 2)      idle(1);
            else if (op < 6) do_req(k, 1'b1, 1'b0, a, $urandom(), 3'($urandom_range(0, 7)));
            else if (op < 9) do_req(k, 1'b0, 1'b1, a, $urandom(), 3'($urandom_range(0, 7)));
            else             do_req(k, 1'b1, 1'b1, a, $urandom(), 3'($urandom_range(0, 7)));
         end
         idle(1);
      end

      idle(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
